// File: rtl/scc_pkg.sv
// scc_pkg: shared constants and types for the SCC tone mixer
package scc_pkg;
  localparam int CH_COUNT = 5;
  localparam int SLOT_COUNT = 6;
  localparam int FREQ_W = 12;
  localparam int PTR_W = 5;
  localparam int VOL_W = 4;
  localparam int SAMPLE_W = 8;
  localparam int PROD_W = 12;
  localparam int ACC_W = 15;
  localparam logic [FREQ_W-1:0] MIN_FREQ = FREQ_W'(9);
  typedef logic [2:0] slot_t;
  localparam slot_t LAST_SLOT = slot_t'(SLOT_COUNT - 1);
  localparam slot_t LAST_CH = slot_t'(CH_COUNT - 1);
endpackage

// File: rtl/scc_tone_mixer_if.sv
// scc_tone_mixer_if: wave RAM read bus between the mixer and the sample memory
interface scc_tone_mixer_if;
  import scc_pkg::*;
  logic wave_re;
  slot_t wave_id;
  logic [PTR_W-1:0] wave_a;
  logic signed [SAMPLE_W-1:0] wave_q;
  modport master (output wave_re, wave_id, wave_a, input wave_q);
  modport slave (input wave_re, wave_id, wave_a, output wave_q);
endinterface

// File: rtl/scc_wave_mac.sv
// scc_wave_mac: scales each wave sample by its volume and sums one round into a mixed sample
module scc_wave_mac
  import scc_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic issue,
  input logic last,
  input logic [VOL_W-1:0] vol,
  input logic en,
  input logic signed [SAMPLE_W-1:0] sample,
  output logic signed [ACC_W-1:0] sound_out,
  output logic sound_valid
);
  logic v1, last1, en1;
  logic [VOL_W-1:0] vol1;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0] acc, sum;
  always_comb begin
    product = en1 ? PROD_W'(sample) * $signed(PROD_W'(vol1)) : '0;
    sum = acc + ACC_W'(product);
  end
  // volume/enable ride one stage behind the read so they meet the returning sample
  always_ff @(posedge clk)
    if (reset) begin
      v1 <= 1'b0;
      last1 <= 1'b0;
      en1 <= 1'b0;
      vol1 <= '0;
      acc <= '0;
      sound_out <= '0;
      sound_valid <= 1'b0;
    end else begin
      v1 <= issue;
      last1 <= last;
      en1 <= en;
      vol1 <= vol;
      sound_valid <= v1 && last1;
      if (v1) acc <= last1 ? '0 : sum;
      if (v1 && last1) sound_out <= sum;
    end
endmodule

// File: rtl/scc_tone_mixer.sv
// scc_tone_mixer: time-multiplexed 5-channel wavetable tone generator and mixer
module scc_tone_mixer
  import scc_pkg::*;
(
  input logic clk,
  input logic reset,
  output slot_t active,
  input logic [FREQ_W-1:0] reg_frequency_count0,
  input logic [VOL_W-1:0] reg_volume0,
  input logic reg_enable0,
  input logic [CH_COUNT-1:0] ch_reset,
  scc_tone_mixer_if.master wave,
  output logic signed [ACC_W-1:0] sound_out,
  output logic sound_valid
);
  logic [FREQ_W-1:0] cnt [CH_COUNT];
  logic [PTR_W-1:0] ptr [CH_COUNT];
  logic [CH_COUNT-1:0] pending;
  logic [VOL_W-1:0] vol0;
  logic en0, is_ch, restart, run, reload;
  slot_t sel;
  logic [FREQ_W-1:0] cnt_nx;
  logic [PTR_W-1:0] ptr_nx;
  // a restart request wins over the tone counter in the channel's own slot
  always_comb begin
    is_ch = active != LAST_SLOT;
    sel = is_ch ? active : '0;
    restart = pending[sel] | ch_reset[sel];
    run = reg_frequency_count0 >= MIN_FREQ;
    reload = run && cnt[sel] == '0;
    cnt_nx = restart || reload ? reg_frequency_count0 : run ? cnt[sel] - 1'b1 : cnt[sel];
    ptr_nx = restart ? '0 : reload ? ptr[sel] + 1'b1 : ptr[sel];
  end
  always_ff @(posedge clk)
    if (reset) begin
      active <= '0;
      pending <= '0;
      for (int i = 0; i < CH_COUNT; i++) begin
        cnt[i] <= '0;
        ptr[i] <= '0;
      end
      wave.wave_re <= 1'b0;
      wave.wave_id <= '0;
      wave.wave_a <= '0;
      vol0 <= '0;
      en0 <= 1'b0;
    end else begin
      active <= is_ch ? active + 1'b1 : '0;
      pending <= (pending | ch_reset) & ~(CH_COUNT'(is_ch) << sel);
      wave.wave_re <= is_ch;
      if (is_ch) begin
        cnt[sel] <= cnt_nx;
        ptr[sel] <= ptr_nx;
        wave.wave_id <= sel;
        wave.wave_a <= ptr_nx;
        vol0 <= reg_volume0;
        en0 <= reg_enable0;
      end
    end
  scc_wave_mac mac (
    .clk(clk),
    .reset(reset),
    .issue(wave.wave_re),
    .last(wave.wave_id == LAST_CH),
    .vol(vol0),
    .en(en0),
    .sample(wave.wave_q),
    .sound_out(sound_out),
    .sound_valid(sound_valid)
  );
endmodule

// File: tb/tb_scc_tone_mixer.sv
// tb_scc_tone_mixer: directed scenarios checked against a per-slot behavioural model every cycle
module tb_scc_tone_mixer;
  import scc_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  slot_t active;
  logic [11:0] reg_frequency_count0;
  logic [3:0] reg_volume0;
  logic reg_enable0;
  logic [4:0] ch_reset = '0;
  logic signed [14:0] sound_out;
  logic sound_valid;
  logic [11:0] freq [6];
  logic [3:0] vol [6];
  logic en [6];
  logic signed [7:0] ram [5][32];
  int total = 0;
  int bad = 0;
  scc_tone_mixer_if bus ();
  scc_tone_mixer dut (
    .clk(clk),
    .reset(reset),
    .active(active),
    .reg_frequency_count0(reg_frequency_count0),
    .reg_volume0(reg_volume0),
    .reg_enable0(reg_enable0),
    .ch_reset(ch_reset),
    .wave(bus),
    .sound_out(sound_out),
    .sound_valid(sound_valid)
  );
  always #5 clk = ~clk;
  assign reg_frequency_count0 = freq[active];
  assign reg_volume0 = vol[active];
  assign reg_enable0 = en[active];
  always @(posedge clk) if (bus.wave_re) bus.wave_q <= ram[bus.wave_id][bus.wave_a];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // model: channel rules applied slot by slot; the mixed sum is due 3 cycles after channel E's slot
  typedef struct {int due; int val;} snd_t;
  snd_t sq[$];
  bit model_ok = 1'b0;
  int n, round_sum, exp_active, exp_id, exp_a, exp_so;
  bit exp_re, exp_sv;
  int m_cnt [5];
  int m_ptr [5];
  bit m_pend [5];

  task automatic model_step();
    int s, f, contrib;
    snd_t e;
    if (reset) begin
      n = 0;
      round_sum = 0;
      sq.delete();
      for (int i = 0; i < 5; i++) begin
        m_cnt[i] = 0;
        m_ptr[i] = 0;
        m_pend[i] = 1'b0;
      end
      {exp_re, exp_sv} = '0;
      exp_active = 0;
      exp_id = 0;
      exp_a = 0;
      exp_so = 0;
      model_ok = 1'b1;
    end else begin
      s = n % 6;
      for (int i = 0; i < 5; i++) if (ch_reset[i]) m_pend[i] = 1'b1;
      if (s < 5) begin
        f = int'(freq[s]);
        if (m_pend[s]) begin
          m_ptr[s] = 0;
          m_cnt[s] = f;
          m_pend[s] = 1'b0;
        end else if (f >= 9) begin
          if (m_cnt[s] == 0) begin
            m_cnt[s] = f;
            m_ptr[s] = (m_ptr[s] + 1) % 32;
          end else m_cnt[s]--;
        end
        exp_re = 1'b1;
        exp_id = s;
        exp_a = m_ptr[s];
        contrib = en[s] ? int'(ram[s][m_ptr[s]]) * int'(vol[s]) : 0;
        if (s == 4) begin
          e.due = n + 3;
          e.val = round_sum + contrib;
          sq.push_back(e);
          round_sum = 0;
        end else round_sum += contrib;
      end else exp_re = 1'b0;
      n++;
      exp_active = n % 6;
      exp_sv = 1'b0;
      if (sq.size() > 0 && sq[0].due == n) begin
        exp_sv = 1'b1;
        exp_so = sq[0].val;
        void'(sq.pop_front());
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("active", int'(active), exp_active);
      check("wave_re", int'(bus.wave_re), int'(exp_re));
      check("wave_id", int'(bus.wave_id), exp_id);
      check("wave_a", int'(bus.wave_a), exp_a);
      check("sound_valid", int'(sound_valid), int'(exp_sv));
      check("sound_out", int'(sound_out), exp_so);
    end
  end

  task automatic clear_cfg();
    for (int i = 0; i < 6; i++) begin
      freq[i] = '0;
      vol[i] = '0;
      en[i] = 1'b0;
    end
    for (int c = 0; c < 5; c++)
      for (int a = 0; a < 32; a++) ram[c][a] = '0;
  endtask

  task automatic wait_sv(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sound_valid && k < 20);
    if (!sound_valid) k = -1;
  endtask

  task automatic wait_active(input int x);
    for (int i = 0; i < 12 && int'(active) != x; i++) @(negedge clk);
    check("active_sync", int'(active), x);
  endtask

  task automatic wait_read(input int ch, output int a);
    bit hit = 1'b0;
    a = -1;
    for (int i = 0; i < 12; i++) begin
      if (bus.wave_re && int'(bus.wave_id) == ch) begin
        hit = 1'b1;
        a = int'(bus.wave_a);
        break;
      end
      @(negedge clk);
    end
    check("read_sync", int'(hit), 1);
  endtask

  task automatic pulse(input logic [4:0] m);
    ch_reset = m;
    @(negedge clk);
    ch_reset = '0;
  endtask

  initial begin
    int k, a, cnt_re, cnt_sv, nz, last, reads, found_at;
    bit wrapped;
    clear_cfg();
    // silent mixer: cadence of reads and output pulses
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_sv(k);
    check("first_valid_after_reset", k, 7);
    cnt_re = 0;
    cnt_sv = 0;
    repeat (24) begin
      @(negedge clk);
      cnt_re += int'(bus.wave_re);
      cnt_sv += int'(sound_valid);
    end
    check("reads_per_4_rounds", cnt_re, 20);
    check("valids_per_4_rounds", cnt_sv, 4);
    check("silent_out", int'(sound_out), 0);
    // channel A ramp at the slowest running frequency
    reset = 1'b1;
    @(negedge clk);
    clear_cfg();
    freq[0] = 12'd9;
    vol[0] = 4'd15;
    en[0] = 1'b1;
    for (int i = 0; i < 32; i++) ram[0][i] = 8'(i);
    @(negedge clk);
    reset = 1'b0;
    wait_sv(k);
    check("a_first_sample", int'(sound_out), 15);
    repeat (10) wait_sv(k);
    check("a_after_10_rounds", int'(sound_out), 30);
    last = 0;
    wrapped = 1'b0;
    repeat (1900) begin
      @(negedge clk);
      if (bus.wave_re && bus.wave_id == 3'd0) begin
        if (last == 31 && bus.wave_a == 5'd0) wrapped = 1'b1;
        last = int'(bus.wave_a);
      end
    end
    check("a_wraps_31_to_0", int'(wrapped), 1);
    // channel B frozen below the minimum frequency, then released
    reset = 1'b1;
    @(negedge clk);
    clear_cfg();
    freq[1] = 12'd8;
    vol[1] = 4'd15;
    en[1] = 1'b1;
    for (int i = 0; i < 32; i++) ram[1][i] = 8'(i + 1);
    @(negedge clk);
    reset = 1'b0;
    nz = 0;
    repeat (120) begin
      @(negedge clk);
      if (bus.wave_re && bus.wave_id == 3'd1 && bus.wave_a != 5'd0) nz++;
    end
    check("b_frozen_at_8", nz, 0);
    freq[1] = 12'd9;
    reads = 0;
    found_at = -1;
    repeat (100) begin
      @(negedge clk);
      if (bus.wave_re && bus.wave_id == 3'd1) begin
        reads++;
        if (bus.wave_a == 5'd2 && found_at < 0) found_at = reads;
      end
    end
    check("b_second_step_on_read_11", found_at, 11);
    // channel C restart requests, mid-round and in its own slot
    reset = 1'b1;
    @(negedge clk);
    clear_cfg();
    freq[2] = 12'd20;
    vol[2] = 4'd15;
    en[2] = 1'b1;
    for (int i = 0; i < 32; i++) ram[2][i] = 8'(i);
    @(negedge clk);
    reset = 1'b0;
    repeat (150) @(negedge clk);
    wait_read(2, a);
    check("c_ptr_before_restart", a, 2);
    wait_active(0);
    pulse(5'b00100);
    wait_read(2, a);
    check("c_restart_midround", a, 0);
    repeat (132) @(negedge clk);
    wait_read(2, a);
    check("c_ptr_after_restart", a, 1);
    wait_active(2);
    pulse(5'b00100);
    wait_read(2, a);
    check("c_restart_own_slot", a, 0);
    repeat (132) @(negedge clk);
    wait_read(2, a);
    check("c_pending_cleared", a, 1);
    // full-scale negative mix, then reset in slot 3
    reset = 1'b1;
    @(negedge clk);
    clear_cfg();
    for (int c = 0; c < 5; c++) begin
      vol[c] = 4'd15;
      en[c] = 1'b1;
      for (int i = 0; i < 32; i++) ram[c][i] = -8'sd128;
    end
    @(negedge clk);
    reset = 1'b0;
    wait_sv(k);
    check("full_scale_negative", int'(sound_out), -9600);
    wait_active(3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_active", int'(active), 0);
    check("rst_wave_re", int'(bus.wave_re), 0);
    check("rst_wave_id", int'(bus.wave_id), 0);
    check("rst_wave_a", int'(bus.wave_a), 0);
    check("rst_sound_out", int'(sound_out), 0);
    check("rst_sound_valid", int'(sound_valid), 0);
    reset = 1'b0;
    wait_sv(k);
    check("first_valid_after_midreset", k, 7);
    check("full_scale_after_midreset", int'(sound_out), -9600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule

// File: doc/scc_tone_mixer.md
SCC_TONE_MIXER -- requirements
Module: scc_tone_mixer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Port clk, input, 1: system clock, 21.477 MHz (6 slots x 3.58 MHz).
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port active, output, 3: slot counter 0..5; 0..4 = channel A..E, 5 = idle slot; drives the register block's selectors.
REQ-005 Port reg_frequency_count0, input, 12: frequency of the channel named by active, valid in the same cycle.
REQ-006 Port reg_volume0, input, 4: volume of the channel named by active, valid in the same cycle.
REQ-007 Port reg_enable0, input, 1: enable of the channel named by active, valid in the same cycle.
REQ-008 Port ch_reset, input, 5: one-cycle pulse per channel requesting a wave-pointer restart.
REQ-009 Port wave_re, output, 1: wave RAM read strobe.
REQ-010 Port wave_id, output, 3: wave RAM channel select 0..4.
REQ-011 Port wave_a, output, 5: wave RAM sample index.
REQ-012 Port wave_q, input, 8: signed sample, valid the cycle after wave_re.
REQ-013 Port sound_out, output, 15: signed mixed sample.
REQ-014 Port sound_valid, output, 1: one-cycle pulse, once per 6-cycle round, when sound_out updates.

Function
REQ-015 active SHALL count 0,1,2,3,4,5,0,... and advance every clk.
REQ-016 Each channel c SHALL hold a 12-bit down-counter cnt[c] and a 5-bit pointer ptr[c]; both update only in cycles where active==c.
REQ-017 Update in slot c when freq<9: cnt[c] and ptr[c] SHALL hold (channel frozen).
REQ-018 Update in slot c when freq>=9 and cnt[c]==0: cnt[c] SHALL load freq and ptr[c] SHALL increment, wrapping 31->0.
REQ-019 Update in slot c when freq>=9 and cnt[c]!=0: cnt[c] SHALL decrement by 1.
REQ-020 A ch_reset[c] pulse SHALL set a sticky pending[c] bit.
REQ-021 In slot c with pending[c] (or ch_reset[c] in that same cycle), ptr[c]<=0, cnt[c]<=freq, and pending[c] clears; this overrides REQ-017..019.
REQ-022 Pipeline stage 0 (cycle with active==c, c<=4): wave_re=1, wave_id=c, wave_a = updated ptr[c] (the value after REQ-017..021); volume and enable are registered with c.
REQ-023 Stage 0 SHALL NOT be issued for slot 5: wave_re=0 and wave_id/wave_a hold their values.
REQ-024 Stage 1: product = wave_q (signed) x volume (unsigned) -> 12-bit signed; forced to 0 when the registered enable==0.
REQ-025 Stage 2: 15-bit signed accumulator acc += product.
REQ-026 For channel 4, stage 2 SHALL set sound_out <= acc+product, pulse sound_valid, and restart acc with 0.
REQ-027 Latency: channel-4 read to sound_valid SHALL be 2 cycles; sound_valid SHALL repeat every 6 cycles.
REQ-028 No overflow handling is required: worst case 5 x (-128 x 15) = -9600 fits 15 bits.

Reset
REQ-029 On reset, active=0, all cnt=0, all ptr=0, pending=0, acc=0, pipeline valid bits=0, wave_re=0, wave_id=0, wave_a=0, sound_out=0, sound_valid=0.
REQ-030 Reset mid-round SHALL discard the partial accumulation.
REQ-031 After reset, the first sound_valid SHALL occur 7 cycles after reset deassertion.

Structure
REQ-032 Package scc_pkg SHALL hold CH_COUNT=5, SLOT_COUNT=6, MIN_FREQ=9, and the sample, product and accumulator widths.
REQ-033 Multiply-accumulate (stages 1-2) SHALL live in sub-module scc_wave_mac; counters, sequencer and pending bits stay in scc_tone_mixer.

Verification
REQ-034 Scenario: reset, all enables 0 -> sound_valid every 6 cycles with sound_out=0; wave_re high 5 of every 6 cycles.
REQ-035 Scenario: ch A freq=9, volume=15, enable=1, RAM A[n]=n -> wave_a for A steps 1,2,... once every 10 rounds, wraps 31->0; sound_out = 15 x ptr.
REQ-036 Scenario: freq=8 on ch B -> ptr[B] never changes; freq then set to 9 -> ptr[B] advances after 10 rounds.
REQ-037 Scenario: ch_reset[C] pulsed mid-round, and separately in C's own slot -> wave_a=0 for C at its next slot (same slot in the second case); pending clears.
REQ-038 Scenario: all 5 channels sample -128, volume 15, enabled -> sound_out=-9600, no wrap.
REQ-039 Scenario: reset asserted during slot 3 -> acc discarded, all outputs zero next cycle, first sound_valid 7 cycles after deassertion.
